// File: rtl/mips_multicycle_ctrl_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : mips_multicycle_ctrl_if
//  Brief    : Control bus between the multicycle MIPS controller and datapath
//  Revision : 1.0 - initial release
// ============================================================================
interface mips_multicycle_ctrl_if #(
  parameter int OPW  = 6,
  parameter int SELW = 2
);
  logic [OPW-1:0]  opcode;
  logic            mem_ready;
  logic            zero;
  logic            pc_write;
  logic            pc_write_cond;
  logic            iord;
  logic            mem_read;
  logic            mem_write;
  logic            ir_write;
  logic            reg_write;
  logic            alu_src_a;
  logic [1:0]      alu_src_b;
  logic [1:0]      alu_op;
  logic [SELW-1:0] pc_source;
  logic [SELW-1:0] reg_dst;
  logic [SELW-1:0] mem_to_reg;
  logic            illegal_op;
  logic [3:0]      state_dbg;

  // Controller side
  modport master (
    input  opcode, mem_ready, zero,
    output pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
           reg_write, alu_src_a, alu_src_b, alu_op, pc_source, reg_dst,
           mem_to_reg, illegal_op, state_dbg
  );

  // Datapath side
  modport slave (
    output opcode, mem_ready, zero,
    input  pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
           reg_write, alu_src_a, alu_src_b, alu_op, pc_source, reg_dst,
           mem_to_reg, illegal_op, state_dbg
  );
endinterface
`default_nettype wire

// File: rtl/mips_multicycle_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : mips_multicycle_ctrl
//  Brief    : Multicycle MIPS main control FSM with memory-ready stalls
//  Revision : 1.0 - initial release
// ============================================================================
module mips_multicycle_ctrl #(
  parameter int OPW  = 6,
  parameter int SELW = 2
) (
  input  wire logic              clk,
  input  wire logic              rst_n,
  mips_multicycle_ctrl_if.master bus
);

  localparam logic [OPW-1:0] c_OP_RTYPE = OPW'(6'b000000);
  localparam logic [OPW-1:0] c_OP_LW    = OPW'(6'b100011);
  localparam logic [OPW-1:0] c_OP_SW    = OPW'(6'b101011);
  localparam logic [OPW-1:0] c_OP_BEQ   = OPW'(6'b000100);
  localparam logic [OPW-1:0] c_OP_ADDI  = OPW'(6'b001000);
  localparam logic [OPW-1:0] c_OP_J     = OPW'(6'b000010);
  localparam logic [OPW-1:0] c_OP_JAL   = OPW'(6'b000011);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_EXEC     = 4'd6,
    S_R_WB     = 4'd7,
    S_BRANCH   = 4'd8,
    S_JUMP     = 4'd9,
    S_JAL      = 4'd10,
    S_ADDI_EX  = 4'd11,
    S_ADDI_WB  = 4'd12
  } state_t;

  // Moore control word; 'fetch' marks the state whose IR/PC loads wait on mem_ready
  typedef struct packed {
    logic            fetch;
    logic            pc_write;
    logic            pc_write_cond;
    logic            iord;
    logic            mem_read;
    logic            mem_write;
    logic            reg_write;
    logic            alu_src_a;
    logic [1:0]      alu_src_b;
    logic [1:0]      alu_op;
    logic [SELW-1:0] pc_source;
    logic [SELW-1:0] reg_dst;
    logic [SELW-1:0] mem_to_reg;
  } ctrl_t;

  state_t r_state;
  ctrl_t  r_ctrl;
  state_t w_next;

  function automatic logic f_legal(input logic [OPW-1:0] op);
    return (op == c_OP_RTYPE) || (op == c_OP_LW)   || (op == c_OP_SW) ||
           (op == c_OP_BEQ)   || (op == c_OP_ADDI) || (op == c_OP_J)  ||
           (op == c_OP_JAL);
  endfunction

  function automatic state_t f_next(input state_t s, input logic rdy,
                                    input logic [OPW-1:0] op);
    state_t n;
    n = S_FETCH;
    case (s)
      S_FETCH:    n = rdy ? S_DECODE : S_FETCH;
      S_DECODE: begin
        if (op == c_OP_RTYPE)                       n = S_EXEC;
        else if ((op == c_OP_LW) || (op == c_OP_SW)) n = S_MEM_ADDR;
        else if (op == c_OP_BEQ)                    n = S_BRANCH;
        else if (op == c_OP_ADDI)                   n = S_ADDI_EX;
        else if (op == c_OP_J)                      n = S_JUMP;
        else if (op == c_OP_JAL)                    n = S_JAL;
        else                                        n = S_FETCH;
      end
      S_MEM_ADDR: n = (op == c_OP_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:   n = rdy ? S_MEM_WB : S_MEM_RD;
      S_MEM_WR:   n = rdy ? S_FETCH : S_MEM_WR;
      S_EXEC:     n = S_R_WB;
      S_ADDI_EX:  n = S_ADDI_WB;
      default:    n = S_FETCH;
    endcase
    return n;
  endfunction

  function automatic ctrl_t f_decode(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.fetch     = 1'b1;
        c.mem_read  = 1'b1;
        c.alu_src_b = 2'd1;
      end
      S_DECODE:   c.alu_src_b = 2'd3;
      S_MEM_ADDR: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'd2;
      end
      S_MEM_RD: begin
        c.mem_read = 1'b1;
        c.iord     = 1'b1;
      end
      S_MEM_WB: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = SELW'(1);
      end
      S_MEM_WR: begin
        c.mem_write = 1'b1;
        c.iord      = 1'b1;
      end
      S_EXEC: begin
        c.alu_src_a = 1'b1;
        c.alu_op    = 2'd2;
      end
      S_R_WB: begin
        c.reg_write = 1'b1;
        c.reg_dst   = SELW'(1);
      end
      S_BRANCH: begin
        c.alu_src_a     = 1'b1;
        c.alu_op        = 2'd1;
        c.pc_write_cond = 1'b1;
        c.pc_source     = SELW'(1);
      end
      S_ADDI_EX: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'd2;
      end
      S_ADDI_WB:  c.reg_write = 1'b1;
      S_JUMP: begin
        c.pc_write  = 1'b1;
        c.pc_source = SELW'(2);
      end
      // Regfile takes PC (already PC+4) on the same edge the PC takes the target
      S_JAL: begin
        c.pc_write   = 1'b1;
        c.pc_source  = SELW'(2);
        c.reg_write  = 1'b1;
        c.reg_dst    = SELW'(2);
        c.mem_to_reg = SELW'(2);
      end
      default:    c = '0;
    endcase
    return c;
  endfunction

  assign w_next = f_next(r_state, bus.mem_ready, bus.opcode);

  // Control word is registered alongside the state it belongs to
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_FETCH;
      r_ctrl  <= f_decode(S_FETCH);
    end else begin
      r_state <= w_next;
      r_ctrl  <= f_decode(w_next);
    end
  end

  assign bus.pc_write      = rst_n & (r_ctrl.pc_write | (r_ctrl.fetch & bus.mem_ready));
  assign bus.ir_write      = rst_n & r_ctrl.fetch & bus.mem_ready;
  assign bus.pc_write_cond = rst_n & r_ctrl.pc_write_cond;
  assign bus.mem_read      = rst_n & r_ctrl.mem_read;
  assign bus.mem_write     = rst_n & r_ctrl.mem_write;
  assign bus.reg_write     = rst_n & r_ctrl.reg_write;
  assign bus.iord          = r_ctrl.iord;
  assign bus.alu_src_a     = r_ctrl.alu_src_a;
  assign bus.alu_src_b     = r_ctrl.alu_src_b;
  assign bus.alu_op        = r_ctrl.alu_op;
  assign bus.pc_source     = r_ctrl.pc_source;
  assign bus.reg_dst       = r_ctrl.reg_dst;
  assign bus.mem_to_reg    = r_ctrl.mem_to_reg;
  assign bus.illegal_op    = (r_state == S_DECODE) && !f_legal(bus.opcode);
  assign bus.state_dbg     = r_state;

endmodule
`default_nettype wire

// File: tb/tb_mips_multicycle_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_mips_multicycle_ctrl
//  Brief    : Self-checking bench for the multicycle MIPS control FSM
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mips_multicycle_ctrl;

  typedef int q_t[$];

  typedef struct {
    logic [5:0] op;
    int         cycles;
    int         last;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  int   m_state = 0;
  int   m_idx = 0;
  q_t   m_path;
  q_t   trace;

  mips_multicycle_ctrl_if #(.OPW(6), .SELW(2)) bus ();

  mips_multicycle_ctrl #(.OPW(6), .SELW(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic is_legal(input logic [5:0] op);
    return op inside {6'b000000, 6'b100011, 6'b101011, 6'b000100,
                      6'b001000, 6'b000010, 6'b000011};
  endfunction

  // Remaining state walk after DECODE for each instruction class
  function automatic q_t path_of(input logic [5:0] op);
    q_t p;
    case (op)
      6'b000000: p = '{6, 7};
      6'b100011: p = '{2, 3, 4};
      6'b101011: p = '{2, 5};
      6'b000100: p = '{8};
      6'b001000: p = '{11, 12};
      6'b000010: p = '{9};
      6'b000011: p = '{10};
      default:   p = {};
    endcase
    return p;
  endfunction

  // Expected bus outputs, packed as
  // {pcw,pcwc,iord,mr,mw,irw,rw,asa,asb,aop,pcs,rdst,m2r,ill,state}
  function automatic logic [22:0] exp_vec(input int st, input logic rn,
                                          input logic rdy, input logic [5:0] op);
    logic pw = 0, pwc = 0, iord = 0, mr = 0, mw = 0, irw = 0, rw = 0, asa = 0, ill = 0;
    logic [1:0] asb = 0, aop = 0, pcs = 0, rdst = 0, m2r = 0;
    logic [3:0] s4;
    s4 = st[3:0];
    case (st)
      0:  begin mr = 1; asb = 1; irw = rdy; pw = rdy; end
      1:  begin asb = 3; ill = !is_legal(op); end
      2:  begin asa = 1; asb = 2; end
      3:  begin mr = 1; iord = 1; end
      4:  begin rw = 1; m2r = 1; end
      5:  begin mw = 1; iord = 1; end
      6:  begin asa = 1; aop = 2; end
      7:  begin rw = 1; rdst = 1; end
      8:  begin asa = 1; aop = 1; pwc = 1; pcs = 1; end
      9:  begin pw = 1; pcs = 2; end
      10: begin pw = 1; pcs = 2; rw = 1; rdst = 2; m2r = 2; end
      11: begin asa = 1; asb = 2; end
      12: begin rw = 1; end
      default: ;
    endcase
    if (!rn) begin
      pw = 0; pwc = 0; mr = 0; mw = 0; irw = 0; rw = 0;
    end
    return {pw, pwc, iord, mr, mw, irw, rw, asa, asb, aop, pcs, rdst, m2r, ill, s4};
  endfunction

  function automatic logic [22:0] act_vec();
    return {bus.pc_write, bus.pc_write_cond, bus.iord, bus.mem_read, bus.mem_write,
            bus.ir_write, bus.reg_write, bus.alu_src_a, bus.alu_src_b, bus.alu_op,
            bus.pc_source, bus.reg_dst, bus.mem_to_reg, bus.illegal_op, bus.state_dbg};
  endfunction

  task automatic model_advance(input logic rn, input logic rdy, input logic [5:0] op);
    if (!rn) begin
      m_state = 0;
      m_path  = {};
      m_idx   = 0;
    end else if (m_state == 0) begin
      if (rdy) m_state = 1;
    end else if (m_state == 1) begin
      m_path  = path_of(op);
      m_idx   = 0;
      m_state = (m_path.size() > 0) ? m_path[0] : 0;
    end else if (!((m_state == 3 || m_state == 5) && !rdy)) begin
      m_idx++;
      m_state = (m_idx < m_path.size()) ? m_path[m_idx] : 0;
    end
  endtask

  task automatic step(input logic rn, input logic rdy, input logic [5:0] op, input logic z);
    rst_n         = rn;
    bus.mem_ready = rdy;
    bus.opcode    = op;
    bus.zero      = z;
    @(negedge clk);
    trace.push_back(int'(bus.state_dbg));
    chk($sformatf("outputs st=%0d rn=%0b rdy=%0b op=%b", m_state, rn, rdy, op),
        64'(act_vec()), 64'(exp_vec(m_state, rn, rdy, op)));
    model_advance(rn, rdy, op);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] pack_trace(input q_t t);
    logic [63:0] v = '0;
    foreach (t[i]) v = {v[59:0], 4'(t[i])};
    return v;
  endfunction

  vec_t vt[8];
  logic [5:0] pool[7] = '{6'b000000, 6'b100011, 6'b101011, 6'b000100,
                          6'b001000, 6'b000010, 6'b000011};

  initial begin
    int n;
    int last;
    logic [5:0] cur_op;
    logic rn, rdy;
    q_t exp_t;

    vt[0] = '{6'b100011, 5, 4};
    vt[1] = '{6'b101011, 4, 5};
    vt[2] = '{6'b000000, 4, 7};
    vt[3] = '{6'b001000, 4, 12};
    vt[4] = '{6'b000100, 3, 8};
    vt[5] = '{6'b000010, 3, 9};
    vt[6] = '{6'b000011, 3, 10};
    vt[7] = '{6'b111111, 2, 1};

    // Bring the DUT out of its unknown power-up state
    rst_n = 1'b0; bus.mem_ready = 1'b1; bus.opcode = '0; bus.zero = 1'b0;
    @(posedge clk); #1;

    // Reset held 3 clocks with mem_ready=1
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 6'b000000, 1'b0);
    chk("reset_state", 64'(bus.state_dbg), 64'd0);

    // Directed latency table, mem_ready held high
    for (int i = 0; i < 8; i++) begin
      n = 0; last = 0;
      step(1'b1, 1'b1, vt[i].op, 1'b1);
      n = 1;
      while (bus.state_dbg != 4'd0 && n < 16) begin
        last = int'(bus.state_dbg);
        step(1'b1, 1'b1, vt[i].op, 1'b1);
        n++;
      end
      chk($sformatf("latency op=%b", vt[i].op), 64'(n), 64'(vt[i].cycles));
      chk($sformatf("last_state op=%b", vt[i].op), 64'(last), 64'(vt[i].last));
    end

    // jal visits 0,1,10
    trace = {};
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 6'b000011, 1'b0);
    exp_t = '{0, 1, 10};
    chk("jal_trace", pack_trace(trace), pack_trace(exp_t));

    // lw with two wait cycles in MEM_RD
    trace = {};
    step(1'b1, 1'b1, 6'b100011, 1'b0);
    step(1'b1, 1'b1, 6'b100011, 1'b0);
    step(1'b1, 1'b1, 6'b100011, 1'b0);
    step(1'b1, 1'b0, 6'b100011, 1'b0);
    step(1'b1, 1'b0, 6'b100011, 1'b0);
    step(1'b1, 1'b1, 6'b100011, 1'b0);
    step(1'b1, 1'b1, 6'b100011, 1'b0);
    exp_t = '{0, 1, 2, 3, 3, 3, 4};
    chk("lw_stall_trace", pack_trace(trace), pack_trace(exp_t));
    chk("lw_stall_done", 64'(bus.state_dbg), 64'd0);

    // Illegal opcode pulses in DECODE only
    step(1'b1, 1'b1, 6'b111111, 1'b0);
    chk("illegal_in_decode", 64'(bus.illegal_op), 64'd1);
    step(1'b1, 1'b1, 6'b111111, 1'b0);
    chk("illegal_cleared", 64'(bus.illegal_op), 64'd0);
    chk("illegal_to_fetch", 64'(bus.state_dbg), 64'd0);

    // sw stalled in MEM_WR, then reset for one clock
    step(1'b1, 1'b1, 6'b101011, 1'b0);
    step(1'b1, 1'b1, 6'b101011, 1'b0);
    step(1'b1, 1'b1, 6'b101011, 1'b0);
    step(1'b1, 1'b0, 6'b101011, 1'b0);
    chk("sw_stalled_state", 64'(bus.state_dbg), 64'd5);
    rst_n = 1'b0;
    #1;
    chk("sw_rst_mem_write", 64'(bus.mem_write), 64'd0);
    step(1'b0, 1'b0, 6'b101011, 1'b0);
    chk("sw_rst_state", 64'(bus.state_dbg), 64'd0);

    // Randomised traffic against the reference model
    cur_op = 6'b000000;
    for (int c = 0; c < 1500; c++) begin
      if (m_state == 0) begin
        if ($urandom_range(0, 7) == 0) cur_op = 6'($urandom);
        else cur_op = pool[$urandom_range(0, 6)];
      end
      rn  = ($urandom_range(0, 59) != 0);
      rdy = ($urandom_range(0, 3) != 0);
      step(rn, rdy, cur_op, 1'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
